// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide with start/busy/done handshake
module mul_div_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] rs1_value_in,
    input  logic [XLEN-1:0] rs2_value_in,
    input  logic [4:0]      rd_sel_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic [4:0]      rd_sel_out,
    output logic            write_enable_out
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] f3;
    logic [XLEN-1:0] a_mag, b_mag, a_mag_in, b_mag_in, fast_res, q_fix, r_fix, p_hi, res_iter;
    logic [2*XLEN-1:0] prod, prod_nx;
    logic [XLEN:0] rem, rem_nx, r_sh, mul_sum;
    logic [4:0] cnt, rd_lat;
    logic neg_q, neg_r, sa, sb, a_sgn, b_sgn, dz_in, ovf_in, special, ge;
    always_comb begin
        a_sgn    = funct3_in[2] ? ~funct3_in[0] : ^funct3_in[1:0];
        b_sgn    = funct3_in[2] ? ~funct3_in[0] : (funct3_in[1:0] == 2'b01);
        sa       = a_sgn & rs1_value_in[XLEN-1];
        sb       = b_sgn & rs2_value_in[XLEN-1];
        a_mag_in = sa ? -rs1_value_in : rs1_value_in;
        b_mag_in = sb ? -rs2_value_in : rs2_value_in;
        dz_in    = (rs2_value_in == '0);
        ovf_in   = ~funct3_in[0] & (rs1_value_in == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_value_in);
        special  = FAST_SPECIAL && funct3_in[2] && (dz_in || ovf_in);
        fast_res = dz_in ? (funct3_in[1] ? rs1_value_in : '1)
                         : (funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
    end
    // Multiply shifts the multiplier out of prod[XLEN-1:0]; divide shifts the quotient into it
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, a_mag} : '0);
        r_sh     = {rem[XLEN-1:0], prod[XLEN-1]};
        ge       = rem[XLEN] || (r_sh >= {1'b0, b_mag});
        rem_nx   = ge ? r_sh - {1'b0, b_mag} : r_sh;
        prod_nx  = f3[2] ? {{XLEN{1'b0}}, prod[XLEN-2:0], ge} : {mul_sum, prod[XLEN-1:1]};
        p_hi     = neg_q ? ~prod_nx[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, prod_nx[XLEN-1:0] == '0}
                         : prod_nx[2*XLEN-1:XLEN];
        q_fix    = neg_q ? -prod_nx[XLEN-1:0] : prod_nx[XLEN-1:0];
        r_fix    = neg_r ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
        res_iter = !f3[2] ? (f3[1:0] == 2'b00 ? prod_nx[XLEN-1:0] : p_hi)
                          : (f3[1] ? r_fix : (b_mag == '0 ? '1 : q_fix));
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb
        state_nx = state == IDLE ? (start_in ? (special ? DONE : BUSY) : IDLE)
                 : state == BUSY ? (&cnt ? DONE : BUSY)
                 : IDLE;
    always_comb begin
        busy_out         = (state != IDLE);
        done_out         = (state == DONE);
        write_enable_out = (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            f3         <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            cnt        <= '0;
            rd_lat     <= '0;
            prod       <= '0;
            rem        <= '0;
            result_out <= '0;
            rd_sel_out <= '0;
        end else if (state == IDLE && start_in) begin
            f3     <= funct3_in;
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            cnt    <= '0;
            rd_lat <= rd_sel_in;
            rem    <= '0;
            prod   <= {{XLEN{1'b0}}, funct3_in[2] ? a_mag_in : b_mag_in};
            if (special) begin
                result_out <= fast_res;
                rd_sel_out <= rd_sel_in;
            end
        end else if (state == BUSY) begin
            cnt  <= cnt + 5'd1;
            prod <= prod_nx;
            rem  <= rem_nx;
            if (&cnt) begin
                result_out <= res_iter;
                rd_sel_out <= rd_lat;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_in = 1'b0;
    logic [2:0] funct3_in = '0;
    logic [31:0] rs1_value_in = '0, rs2_value_in = '0;
    logic [4:0] rd_sel_in = '0;
    logic busy_out, done_out, write_enable_out;
    logic [31:0] result_out;
    logic [4:0] rd_sel_out;
    typedef struct { logic [4:0] rd; logic [31:0] res; } exp_t;
    exp_t sb[$];
    exp_t e_mon;
    int n_cmp = 0, n_bad = 0, n_done = 0;
    mul_div_unit dut (
        .clk(clk), .rst(rst), .start_in(start_in), .funct3_in(funct3_in),
        .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in), .rd_sel_in(rd_sel_in),
        .busy_out(busy_out), .done_out(done_out), .result_out(result_out),
        .rd_sel_out(rd_sel_out), .write_enable_out(write_enable_out)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (done_out || write_enable_out)
                check("we_eq_done", 32'(write_enable_out), 32'(done_out));
            if (done_out) begin
                n_done++;
                check("sb_depth", 32'(sb.size()), 1);
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    check("result", result_out, e_mon.res);
                    check("rd", {27'b0, rd_sel_out}, {27'b0, e_mon.rd});
                end
            end
        end
    end
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, ua, ub;
        logic [63:0] p;
        int sa, sbv;
        logic ovf;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = pa * pb; return p[63:32]; end
            3'd2: begin p = pa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'(sa / sbv);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'(sa % sbv);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 20));
            2: case ($urandom_range(0, 3))
                   0: return 32'h0;
                   1: return 32'h1;
                   2: return 32'hFFFF_FFFF;
                   default: return 32'h8000_0000;
               endcase
            default: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        endcase
    endfunction
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int n = 0;
        @(negedge clk);
        funct3_in = f;
        rs1_value_in = a;
        rs2_value_in = b;
        rd_sel_in = rd;
        start_in = 1'b1;
        sb.push_back('{rd: rd, res: exp});
        @(posedge clk);
        #1;
        start_in = 1'b0;
        rs1_value_in = $urandom;
        rs2_value_in = $urandom;
        rd_sel_in = 5'($urandom);
        funct3_in = 3'($urandom);
        while (!done_out && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, lat);
        @(posedge clk);
        #1;
        check("hold", result_out, exp);
        check("idle", 32'(busy_out), 0);
    endtask
    initial begin
        int d0, n, busy_low;
        logic [2:0] f;
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_we", 32'(write_enable_out), 0);
        check("rst_result", result_out, 0);
        check("rst_rd", {27'b0, rd_sel_out}, 0);
        rst = 1'b0;
        d0 = n_done;
        do_op(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 32);
        check("mul_pulses", n_done - d0, 1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd1, 32'hFFFF_FFFF, 32);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd2, 32'hFFFF_FFFF, 32);
        do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h0000_0001, 32);
        do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd4, 32'hFFFF_FFFE, 32);
        do_op(3'd4, -32'd7, 32'd2, 5'd6, 32'hFFFF_FFFD, 32);
        do_op(3'd6, -32'd7, 32'd2, 5'd7, 32'hFFFF_FFFF, 32);
        do_op(3'd5, 32'd100, 32'd7, 5'd8, 32'd14, 32);
        do_op(3'd7, 32'd100, 32'd7, 5'd9, 32'd2, 32);
        do_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 0);
        do_op(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 0);
        do_op(3'd6, -32'd5, 32'd0, 5'd12, 32'hFFFF_FFFB, 0);
        do_op(3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 0);
        do_op(3'd7, 32'h8000_0000, 32'd0, 5'd14, 32'h8000_0000, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, 32);
        // start held high through BUSY while a second request is presented
        d0 = n_done;
        n = 0;
        busy_low = 0;
        @(negedge clk);
        funct3_in = 3'd0;
        rs1_value_in = 32'd3;
        rs2_value_in = 32'd5;
        rd_sel_in = 5'd20;
        start_in = 1'b1;
        sb.push_back('{rd: 5'd20, res: 32'd15});
        @(posedge clk);
        #1;
        funct3_in = 3'd5;
        rs1_value_in = 32'd100;
        rs2_value_in = 32'd3;
        rd_sel_in = 5'd21;
        while (!done_out && n < 100) begin
            if (!busy_out) busy_low++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!busy_out) busy_low++;
        start_in = 1'b0;
        check("held_latency", n, 32);
        check("held_busy_low", busy_low, 0);
        repeat (40) @(posedge clk);
        #1;
        check("held_pulses", n_done - d0, 1);
        // reset mid-operation aborts without a write
        d0 = n_done;
        @(negedge clk);
        funct3_in = 3'd5;
        rs1_value_in = 32'd1000;
        rs2_value_in = 32'd9;
        rd_sel_in = 5'd22;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy_out), 0);
        check("abort_done", 32'(done_out), 0);
        check("abort_we", 32'(write_enable_out), 0);
        check("abort_result", result_out, 0);
        check("abort_rd", {27'b0, rd_sel_out}, 0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_pulses", n_done - d0, 0);
        do_op(3'd5, 32'd1000, 32'd9, 5'd23, 32'd111, 32);
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            do_op(f, a, b, 5'($urandom), model(f, a, b),
                  (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
